// File: rtl/usb_packet_buffer_pkg.sv
// ---------------------------------------------------------------------------
// usb_buf_pkg
// Shared constants and small enums for the USB endpoint packet buffer.
//   DEFAULT_DEPTH / DEFAULT_DATA_W : default geometry (64 x 8 bits)
//   DEFAULT_AW / DEFAULT_PTR_W     : entry index width and wrap-bit pointer width
//   DEFAULT_OCC_W                  : occupancy width, able to hold the value DEPTH
//   rd_sel_e                       : which read port owns the current read
//   snap_op_e                      : resolved mark/rewind/release operation
// ---------------------------------------------------------------------------
package usb_buf_pkg;

  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_AW     = $clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_PTR_W  = DEFAULT_AW + 1;
  localparam int DEFAULT_OCC_W  = $clog2(DEFAULT_DEPTH + 1);

  // The USB TX side wins a same-cycle read against the AHB side.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_TX   = 2'd1,
    RD_RX   = 2'd2
  } rd_sel_e;

  // Encoded in priority order: rewind > mark > release.
  typedef enum logic [1:0] {
    SNAP_NONE    = 2'd0,
    SNAP_REWIND  = 2'd1,
    SNAP_MARK    = 2'd2,
    SNAP_RELEASE = 2'd3
  } snap_op_e;

endpackage

// File: rtl/usb_packet_buffer_if.sv
// ---------------------------------------------------------------------------
// usb_packet_buffer_if
// Groups every non-clock/non-reset signal of the packet buffer.
//   slave  modport : the buffer itself (strobes/data in, read data and status out)
//   master modport : the surrounding endpoint (AHB slave + USB TX/RX controllers)
// Signals:
//   clear                                   synchronous flush
//   store_tx_data / tx_data                 AHB-side write
//   get_rx_data / rx_data                   AHB-side read (registered data)
//   store_rx_packet_data / rx_packet_data   USB RX write
//   get_tx_packet_data / tx_packet_data     USB TX read (registered data)
//   mark / rewind / release_mark            retransmit snapshot control
//   buffer_occupancy, full, empty           status
//   overflow, underflow                     sticky error flags
// The drop-snapshot strobe is called release_mark because "release" is a
// reserved word in SystemVerilog.
// ---------------------------------------------------------------------------
interface usb_packet_buffer_if
  import usb_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int OCC_W  = DEFAULT_OCC_W
);

  logic              clear;
  logic              store_tx_data;
  logic [DATA_W-1:0] tx_data;
  logic              get_rx_data;
  logic [DATA_W-1:0] rx_data;
  logic              store_rx_packet_data;
  logic [DATA_W-1:0] rx_packet_data;
  logic              get_tx_packet_data;
  logic [DATA_W-1:0] tx_packet_data;
  logic              mark;
  logic              rewind;
  logic              release_mark;
  logic [OCC_W-1:0]  buffer_occupancy;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  clear,
    input  store_tx_data, tx_data,
    input  get_rx_data,
    output rx_data,
    input  store_rx_packet_data, rx_packet_data,
    input  get_tx_packet_data,
    output tx_packet_data,
    input  mark, rewind, release_mark,
    output buffer_occupancy, full, empty, overflow, underflow
  );

  modport master (
    output clear,
    output store_tx_data, tx_data,
    output get_rx_data,
    input  rx_data,
    output store_rx_packet_data, rx_packet_data,
    output get_tx_packet_data,
    input  tx_packet_data,
    output mark, rewind, release_mark,
    input  buffer_occupancy, full, empty, overflow, underflow
  );

endinterface

// File: rtl/usb_packet_buffer_mem.sv
// ---------------------------------------------------------------------------
// buffer_mem
// DEPTH x DATA_W storage array for the packet buffer.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module buffer_mem #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; pointers alone decide which entries are
  // valid, and leaving the array unreset lets it map onto RAM/plain flops.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for every clocked state update, so all
    // flops sample the pre-edge values regardless of statement order.
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_packet_buffer.sv
// ---------------------------------------------------------------------------
// usb_packet_buffer
// Shared circular FIFO between the AHB-lite slave and the USB TX/RX
// controllers, with registered read data, sticky overflow/underflow flags
// and a mark/rewind/release snapshot so a TX packet can be replayed.
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : usb_packet_buffer_if.slave (strobes, data, status, flags)
// Pointers carry one extra wrap bit so full and empty are distinguished by
// plain subtraction. While a snapshot is held, entries read since the mark
// stay reserved: fullness is measured from the mark pointer, not the read
// pointer.
// ---------------------------------------------------------------------------
module usb_packet_buffer
  import usb_buf_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,   // power of two, 4..256
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  usb_packet_buffer_if.slave   bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Registered state and next-state
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  mptr_q, mptr_d;
  logic              hold_q, hold_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  // Status derived from the pre-cycle pointers
  logic [PTR_W-1:0]  occupancy;
  logic [PTR_W-1:0]  reserved;
  logic              full_w;
  logic              empty_w;

  assign occupancy = wptr_q - rptr_q;
  assign reserved  = wptr_q - mptr_q;
  assign full_w    = (reserved == PTR_W'(DEPTH));
  assign empty_w   = (occupancy == '0);

  // Write decode: RX beats TX on a collision, and the loser counts as an overflow.
  logic              wr_req;
  logic              wr_collide;
  logic              wr_accept;
  logic [DATA_W-1:0] wr_data;

  assign wr_req     = bus.store_rx_packet_data | bus.store_tx_data;
  assign wr_collide = bus.store_rx_packet_data & bus.store_tx_data;
  assign wr_accept  = wr_req & ~full_w;
  assign wr_data    = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;

  // Read and snapshot decode
  rd_sel_e  rd_sel;
  snap_op_e snap_op;
  logic     rd_req;
  logic     rd_accept;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    rd_sel = RD_NONE;
    if (bus.get_tx_packet_data) begin
      rd_sel = RD_TX;
    end else if (bus.get_rx_data) begin
      rd_sel = RD_RX;
    end

    // Rewind only means something while a snapshot is held; otherwise it
    // falls through so a mark or release in the same cycle still applies.
    snap_op = SNAP_NONE;
    if (bus.rewind && hold_q) begin
      snap_op = SNAP_REWIND;
    end else if (bus.mark) begin
      snap_op = SNAP_MARK;
    end else if (bus.release_mark) begin
      snap_op = SNAP_RELEASE;
    end
  end

  // A rewind moves the read pointer itself, so it swallows any same-cycle read.
  assign rd_req    = (rd_sel != RD_NONE) && (snap_op != SNAP_REWIND);
  assign rd_accept = rd_req && !empty_w;

  // Storage
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign mem_we = wr_accept & ~bus.clear;

  buffer_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next-state logic
  logic [PTR_W-1:0] rptr_adv;

  assign rptr_adv = rd_accept ? rptr_q + PTR_W'(1) : rptr_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    mptr_d      = mptr_q;
    hold_d      = hold_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rx_data_d   = rx_data_q;
    tx_data_d   = tx_data_q;

    if (bus.clear) begin
      wptr_d      = '0;
      rptr_d      = '0;
      mptr_d      = '0;
      hold_d      = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      rx_data_d   = '0;
      tx_data_d   = '0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if ((wr_req && full_w) || wr_collide) begin
        overflow_d = 1'b1;
      end
      if (rd_req && empty_w) begin
        underflow_d = 1'b1;
      end

      if (rd_accept) begin
        unique case (rd_sel)
          RD_TX:   tx_data_d = mem_rdata;
          RD_RX:   rx_data_d = mem_rdata;
          default: ;
        endcase
      end

      unique case (snap_op)
        SNAP_REWIND: begin
          rptr_d = mptr_q;
        end
        SNAP_MARK: begin
          // Snapshot the pre-read pointer so a same-cycle read stays replayable.
          rptr_d = rptr_adv;
          mptr_d = rptr_q;
          hold_d = 1'b1;
        end
        SNAP_RELEASE: begin
          rptr_d = rptr_adv;
          mptr_d = rptr_adv;
          hold_d = 1'b0;
        end
        default: begin
          rptr_d = rptr_adv;
          if (!hold_q) begin
            mptr_d = rptr_adv;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      mptr_q      <= '0;
      hold_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rx_data_q   <= '0;
      tx_data_q   <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mptr_q      <= mptr_d;
      hold_q      <= hold_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rx_data_q   <= rx_data_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Outputs
  assign bus.rx_data          = rx_data_q;
  assign bus.tx_packet_data   = tx_data_q;
  assign bus.buffer_occupancy = occupancy;
  assign bus.full             = full_w;
  assign bus.empty            = empty_w;
  assign bus.overflow         = overflow_q;
  assign bus.underflow        = underflow_q;

endmodule

// File: tb/tb_usb_packet_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_packet_buffer
// Drives the packet buffer on falling edges, steps a queue-based reference
// model (unread entries plus entries consumed since the last mark) and
// pushes the expected post-edge state into a scoreboard queue. A separate
// monitor pops one record per rising edge and compares every output.
// ---------------------------------------------------------------------------
module tb_usb_packet_buffer;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 8;
  localparam int OCC_W  = 7;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  usb_packet_buffer_if #(.DATA_W(DATA_W), .OCC_W(OCC_W)) bus ();

  usb_packet_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    bit       rst, clr;
    bit       s_tx, s_rx, g_rx, g_tx;
    bit       mk, rw, rl;
    bit [7:0] d_tx, d_rx;
  } stim_t;

  typedef struct {
    int       cyc;
    int       occ;
    bit       full, empty, ovf, unf;
    bit [7:0] rx, tx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // ---------------- reference model ----------------
  bit [7:0] m_fifo[$];   // unread entries, oldest first
  bit [7:0] m_cons[$];   // entries read since the mark (only while holding)
  bit       m_hold, m_ovf, m_unf;
  bit [7:0] m_rx, m_tx;

  function automatic void model_reset();
    m_fifo.delete();
    m_cons.delete();
    m_hold = 0; m_ovf = 0; m_unf = 0;
    m_rx = 0; m_tx = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    bit       was_full, was_empty;
    bit [7:0] v;
    if (s.rst || s.clr) begin
      model_reset();
      return;
    end
    was_full  = (m_fifo.size() + m_cons.size()) == DEPTH;
    was_empty = (m_fifo.size() == 0);
    if (s.rw && m_hold) begin
      m_fifo = {m_cons, m_fifo};
      m_cons.delete();
    end else begin
      if (s.mk) begin
        m_hold = 1; m_cons.delete();
      end else if (s.rl) begin
        m_hold = 0; m_cons.delete();
      end
      if (s.g_tx || s.g_rx) begin
        if (was_empty) m_unf = 1;
        else begin
          v = m_fifo.pop_front();
          if (m_hold) m_cons.push_back(v);
          if (s.g_tx) m_tx = v;
          else        m_rx = v;
        end
      end
    end
    if (s.s_rx && s.s_tx) m_ovf = 1;
    if (s.s_rx || s.s_tx) begin
      if (was_full) m_ovf = 1;
      else m_fifo.push_back(s.s_rx ? s.d_rx : s.d_tx);
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    n_rst                    = !s.rst;
    bus.clear                = s.clr;
    bus.store_tx_data        = s.s_tx;
    bus.tx_data              = s.d_tx;
    bus.store_rx_packet_data = s.s_rx;
    bus.rx_packet_data       = s.d_rx;
    bus.get_rx_data          = s.g_rx;
    bus.get_tx_packet_data   = s.g_tx;
    bus.mark                 = s.mk;
    bus.rewind               = s.rw;
    bus.release_mark         = s.rl;
    model_step(s);
    cyc++;
    e.cyc   = cyc;
    e.occ   = m_fifo.size();
    e.full  = (m_fifo.size() + m_cons.size()) == DEPTH;
    e.empty = (m_fifo.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.rx    = m_rx;
    e.tx    = m_tx;
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s = '{default: 0};
    return s;
  endfunction

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  task automatic do_write(input bit use_rx, input bit [7:0] d);
    stim_t s = idle();
    if (use_rx) begin s.s_rx = 1; s.d_rx = d; end
    else        begin s.s_tx = 1; s.d_tx = d; end
    step(s);
  endtask

  task automatic do_read(input bit use_tx, input int n);
    stim_t s = idle();
    if (use_tx) s.g_tx = 1; else s.g_rx = 1;
    for (int i = 0; i < n; i++) step(s);
  endtask

  task automatic do_ctl(input bit mk, input bit rw, input bit rl, input bit clr, input bit rst);
    stim_t s = idle();
    s.mk = mk; s.rw = rw; s.rl = rl; s.clr = clr; s.rst = rst;
    step(s);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("occupancy", e.cyc, 32'(bus.buffer_occupancy), 32'(e.occ));
        check("full",      e.cyc, 32'(bus.full),             32'(e.full));
        check("empty",     e.cyc, 32'(bus.empty),            32'(e.empty));
        check("overflow",  e.cyc, 32'(bus.overflow),         32'(e.ovf));
        check("underflow", e.cyc, 32'(bus.underflow),        32'(e.unf));
        check("rx_data",   e.cyc, 32'(bus.rx_data),          32'(e.rx));
        check("tx_data",   e.cyc, 32'(bus.tx_packet_data),   32'(e.tx));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    stim_t s;
    int    wr_bias;

    bus.clear = 0; bus.store_tx_data = 0; bus.tx_data = 0;
    bus.store_rx_packet_data = 0; bus.rx_packet_data = 0;
    bus.get_rx_data = 0; bus.get_tx_packet_data = 0;
    bus.mark = 0; bus.rewind = 0; bus.release_mark = 0;
    model_reset();

    // Reset, then idle
    do_ctl(0, 0, 0, 0, 1);
    do_ctl(0, 0, 0, 0, 1);
    do_idle(2);

    // Two writes, two TX reads with one-cycle data latency
    do_write(0, 8'hA5);
    do_write(0, 8'h3C);
    do_read(1, 2);
    do_idle(1);

    // Fill to DEPTH, one more write overflows, then clear
    for (int i = 0; i < DEPTH; i++) do_write(0, 8'(i + 8'h40));
    do_write(0, 8'hFF);
    do_idle(1);
    do_ctl(0, 0, 0, 1, 0);
    do_idle(1);

    // Mark, read 8, rewind, release, read 8 again
    for (int i = 1; i <= 8; i++) do_write(0, 8'(i));
    do_ctl(1, 0, 0, 0, 0);
    do_read(1, 8);
    do_ctl(0, 1, 0, 0, 0);
    do_idle(1);
    do_ctl(0, 0, 1, 0, 0);
    do_read(1, 8);
    do_idle(1);

    // Held entries block a write until release
    do_ctl(0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) do_write(i[0], 8'($urandom));
    do_ctl(1, 0, 0, 0, 0);
    do_read(1, 60);
    do_write(0, 8'h77);
    do_ctl(0, 0, 1, 0, 0);
    do_write(0, 8'h77);
    do_idle(1);

    // Write collision, RX read, then RX read on empty
    do_ctl(0, 0, 0, 1, 0);
    s = idle(); s.s_tx = 1; s.d_tx = 8'h11; s.s_rx = 1; s.d_rx = 8'h22;
    step(s);
    do_read(0, 1);
    do_read(0, 1);
    do_idle(1);

    // Reset in the middle of a held packet, rewind afterwards is a no-op
    do_ctl(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) do_write(1, 8'(8'hC0 + i));
    s = idle(); s.mk = 1; s.g_tx = 1; step(s);
    do_read(1, 2);
    do_ctl(0, 0, 0, 0, 1);
    do_idle(1);
    do_ctl(0, 1, 0, 0, 0);
    do_write(0, 8'h5A);
    do_read(1, 1);

    // Randomised traffic, alternating write-heavy and read-heavy phases
    for (int c = 0; c < 2000; c++) begin
      s = idle();
      wr_bias = ((c / 150) % 2 == 0) ? 70 : 30;
      if ($urandom_range(99) < wr_bias) begin
        if ($urandom_range(9) == 0) begin
          s.s_tx = 1; s.s_rx = 1;
        end else if ($urandom_range(1) == 1) s.s_tx = 1;
        else s.s_rx = 1;
        s.d_tx = 8'($urandom);
        s.d_rx = 8'($urandom);
      end
      if ($urandom_range(99) < 100 - wr_bias) begin
        case ($urandom_range(5))
          0:       s.g_rx = 1;
          1:       begin s.g_rx = 1; s.g_tx = 1; end
          default: s.g_tx = 1;
        endcase
      end
      if ($urandom_range(19) == 0) s.mk = 1;
      if ($urandom_range(24) == 0) s.rw = 1;
      if ($urandom_range(39) == 0) s.rl = 1;
      if ($urandom_range(299) == 0) s.clr = 1;
      if ($urandom_range(499) == 0) s.rst = 1;
      step(s);
    end
    do_idle(2);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
